// File: rtl/store_phase_if.sv
`default_nettype none
// ============================================================================
// Module      : store_phase_if
// Description : Store-request handshake bundle between the execute stage
//               (master) and the store-phase commit block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface store_phase_if;
    logic       st_valid;
    logic       st_ready;
    logic [7:0] st_addr;
    logic [7:0] st_data;

    // Execute stage side: presents requests, observes back-pressure
    modport master (
        output st_valid,
        output st_addr,
        output st_data,
        input  st_ready
    );

    // Store-phase side: consumes requests, drives back-pressure
    modport slave (
        input  st_valid,
        input  st_addr,
        input  st_data,
        output st_ready
    );
endinterface : store_phase_if
`default_nettype wire

// File: rtl/store_phase.sv
`default_nettype none
// ============================================================================
// Module      : store_phase
// Description : Write-side address map. Buffers 8-bit store requests in a
//               2-entry posting FIFO and commits them in order to the data
//               RAM strobe, one of 16 output port registers, or flags a
//               sticky error for stores into read-only space.
// Revision    : 1.0 - initial release
// ============================================================================
module store_phase #(
    parameter logic [7:0] RAM_LO    = 8'h80,
    parameter logic [7:0] RAM_HI    = 8'hDF,
    parameter logic [7:0] PORT_BASE = 8'hE0
) (
    input  wire logic        clk,
    input  wire logic        rst,          // asynchronous, active-low
    store_phase_if.slave     st,
    input  wire logic        hold,
    input  wire logic        clr_err,
    output logic             ram_we,
    output logic [7:0]       ram_addr,
    output logic [7:0]       ram_wdata,
    output logic [7:0]       port_out_00,
    output logic [7:0]       port_out_01,
    output logic [7:0]       port_out_02,
    output logic [7:0]       port_out_03,
    output logic [7:0]       port_out_04,
    output logic [7:0]       port_out_05,
    output logic [7:0]       port_out_06,
    output logic [7:0]       port_out_07,
    output logic [7:0]       port_out_08,
    output logic [7:0]       port_out_09,
    output logic [7:0]       port_out_10,
    output logic [7:0]       port_out_11,
    output logic [7:0]       port_out_12,
    output logic [7:0]       port_out_13,
    output logic [7:0]       port_out_14,
    output logic [7:0]       port_out_15,
    output logic [15:0]      port_strobe,
    output logic             bad_addr,
    output logic [7:0]       wr_count
);

    localparam int unsigned c_DEPTH     = 2;
    localparam int unsigned c_NUM_PORTS = 16;
    localparam logic [1:0]  c_FULL      = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Posting FIFO storage and bookkeeping
    logic [7:0]  r_fifo_addr [c_DEPTH];
    logic [7:0]  r_fifo_data [c_DEPTH];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;

    logic        w_push;
    logic        w_pop;

    // Head-of-FIFO decode
    logic [7:0]  w_head_addr;
    logic [7:0]  w_head_data;
    logic [7:0]  w_port_off;
    logic [3:0]  w_port_idx;
    logic        w_is_ram;
    logic        w_is_port;
    logic        w_commit_ram;
    logic        w_commit_port;
    logic        w_commit_bad;

    // Registered outputs
    logic        r_ram_we;
    logic [7:0]  r_ram_addr;
    logic [7:0]  r_ram_wdata;
    logic [15:0] r_port_strobe;
    logic        r_bad_addr;
    logic [7:0]  r_wr_count;
    logic [7:0]  r_port [c_NUM_PORTS];

    // ------------------------------------------------------------------
    // Handshake and pop qualification
    // ------------------------------------------------------------------
    assign st.st_ready = (r_count != c_FULL);
    assign w_push      = st.st_valid && st.st_ready;
    // hold is sampled live so the edge carrying hold=1 never pops, and the
    // first edge with hold=0 commits straight away from either RUN or STALL.
    assign w_pop       = (r_state != S_IDLE) && (r_count != 2'd0) && !hold;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // ------------------------------------------------------------------
    // Head decode: RAM window takes priority, then the 16-entry port window;
    // anything else (ROM and input-port space) is a read-only violation.
    // ------------------------------------------------------------------
    assign w_head_addr   = r_fifo_addr[r_rd_ptr];
    assign w_head_data   = r_fifo_data[r_rd_ptr];
    assign w_port_off    = w_head_addr - PORT_BASE;
    assign w_port_idx    = w_port_off[3:0];
    assign w_is_ram      = (w_head_addr >= RAM_LO) && (w_head_addr <= RAM_HI);
    assign w_is_port     = !w_is_ram && (w_head_addr >= PORT_BASE) &&
                           (w_port_off[7:4] == 4'd0);
    assign w_commit_ram  = w_pop && w_is_ram;
    assign w_commit_port = w_pop && w_is_port;
    assign w_commit_bad  = w_pop && !w_is_ram && !w_is_port;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: IDLE tracks emptiness, RUN/STALL track hold
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_count_nxt == 2'd0) begin
                    w_state_nxt = S_IDLE;
                end else if (hold) begin
                    w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                // Leaving STALL always goes through RUN, even if the
                // release edge drained the FIFO; RUN then drops to IDLE.
                if (!hold) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO entry storage, written at the tail on each accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_fifo_addr[i] <= 8'h00;
                r_fifo_data[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= st.st_addr;
            r_fifo_data[r_wr_ptr] <= st.st_data;
        end
    end

    // RAM write strobe pulses for one cycle; address/data hold between writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 8'h00;
            r_ram_wdata <= 8'h00;
        end else begin
            r_ram_we <= w_commit_ram;
            if (w_commit_ram) begin
                r_ram_addr  <= w_head_addr;
                r_ram_wdata <= w_head_data;
            end
        end
    end

    // One-hot port strobe, pulses even when the written value is unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port_strobe <= 16'h0000;
        end else if (w_commit_port) begin
            r_port_strobe <= 16'h0001 << w_port_idx;
        end else begin
            r_port_strobe <= 16'h0000;
        end
    end

    // Output port registers, each loaded only by a commit to its own address
    for (genvar gi = 0; gi < c_NUM_PORTS; gi++) begin : g_port
        // Port gi value register
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_port[gi] <= 8'h00;
            end else if (w_commit_port && (w_port_idx == 4'(gi))) begin
                r_port[gi] <= w_head_data;
            end
        end
    end

    // Sticky error: a bad commit on the same edge as clr_err keeps it set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bad_addr <= 1'b0;
        end else if (w_commit_bad) begin
            r_bad_addr <= 1'b1;
        end else if (clr_err) begin
            r_bad_addr <= 1'b0;
        end
    end

    // Good-write counter, wraps silently from 0xFF to 0x00
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= 8'h00;
        end else if (w_commit_ram || w_commit_port) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign port_strobe = r_port_strobe;
    assign bad_addr    = r_bad_addr;
    assign wr_count    = r_wr_count;

    assign port_out_00 = r_port[0];
    assign port_out_01 = r_port[1];
    assign port_out_02 = r_port[2];
    assign port_out_03 = r_port[3];
    assign port_out_04 = r_port[4];
    assign port_out_05 = r_port[5];
    assign port_out_06 = r_port[6];
    assign port_out_07 = r_port[7];
    assign port_out_08 = r_port[8];
    assign port_out_09 = r_port[9];
    assign port_out_10 = r_port[10];
    assign port_out_11 = r_port[11];
    assign port_out_12 = r_port[12];
    assign port_out_13 = r_port[13];
    assign port_out_14 = r_port[14];
    assign port_out_15 = r_port[15];

endmodule : store_phase
`default_nettype wire

// File: tb/tb_store_phase.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_phase
// Description : Directed self-checking bench for store_phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_phase;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        clr_err;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  p00, p01, p02, p03, p04, p05, p06, p07;
    logic [7:0]  p08, p09, p10, p11, p12, p13, p14, p15;
    logic [15:0] port_strobe;
    logic        bad_addr;
    logic [7:0]  wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    store_phase_if bus ();

    store_phase dut (
        .clk         (clk),
        .rst         (rst),
        .st          (bus),
        .hold        (hold),
        .clr_err     (clr_err),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .port_out_00 (p00),
        .port_out_01 (p01),
        .port_out_02 (p02),
        .port_out_03 (p03),
        .port_out_04 (p04),
        .port_out_05 (p05),
        .port_out_06 (p06),
        .port_out_07 (p07),
        .port_out_08 (p08),
        .port_out_09 (p09),
        .port_out_10 (p10),
        .port_out_11 (p11),
        .port_out_12 (p12),
        .port_out_13 (p13),
        .port_out_14 (p14),
        .port_out_15 (p15),
        .port_strobe (port_strobe),
        .bad_addr    (bad_addr),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request from a negedge; returns at the negedge after the
    // accepting edge with st_valid dropped. Commit is visible one negedge later.
    task automatic send(input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        while (!bus.st_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.st_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        rst          = 1'b0;
        hold         = 1'b0;
        clr_err      = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_addr  = 8'h00;
        bus.st_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",   32'(bus.st_ready), 32'd1);
        check("rst_ram_we",  32'(ram_we),       32'd0);
        check("rst_ram_addr",32'(ram_addr),     32'h00);
        check("rst_strobe",  32'(port_strobe),  32'h0000);
        check("rst_bad",     32'(bad_addr),     32'd0);
        check("rst_count",   32'(wr_count),     32'd0);
        check("rst_p00",     32'(p00),          32'h00);
        rst = 1'b1;
        @(negedge clk);

        // RAM store with one-cycle strobe
        send(8'h80, 8'h5A);
        @(negedge clk);
        check("ram1_we",    32'(ram_we),    32'd1);
        check("ram1_addr",  32'(ram_addr),  32'h80);
        check("ram1_data",  32'(ram_wdata), 32'h5A);
        check("ram1_count", 32'(wr_count),  32'd1);
        @(negedge clk);
        check("ram1_we_off", 32'(ram_we),   32'd0);

        // Port stores
        send(8'hE3, 8'hC4);
        @(negedge clk);
        check("p03_val",    32'(p03),         32'hC4);
        check("p03_strobe", 32'(port_strobe), 32'h0008);
        @(negedge clk);
        check("p03_strobe_off", 32'(port_strobe), 32'h0000);
        send(8'hEF, 8'h11);
        @(negedge clk);
        check("p15_val",    32'(p15),         32'h11);
        check("p15_strobe", 32'(port_strobe), 32'h8000);
        check("p03_hold",   32'(p03),         32'hC4);

        // Window boundaries: 0xDF is RAM, 0xE0 is port 0
        send(8'hDF, 8'h77);
        @(negedge clk);
        check("dF_we",   32'(ram_we),   32'd1);
        check("dF_addr", 32'(ram_addr), 32'hDF);
        send(8'hE0, 8'h99);
        @(negedge clk);
        check("e0_we",     32'(ram_we),      32'd0);
        check("e0_strobe", 32'(port_strobe), 32'h0001);
        check("e0_val",    32'(p00),         32'h99);
        check("count5",    32'(wr_count),    32'd5);

        // Read-only space
        send(8'h10, 8'hAA);
        @(negedge clk);
        check("rom_bad",    32'(bad_addr),    32'd1);
        check("rom_strobe", 32'(port_strobe), 32'h0000);
        check("rom_we",     32'(ram_we),      32'd0);
        check("rom_count",  32'(wr_count),    32'd5);
        send(8'hF5, 8'hBB);
        @(negedge clk);
        check("inp_bad",    32'(bad_addr), 32'd1);
        check("inp_count",  32'(wr_count), 32'd5);
        send(8'h00, 8'hCC);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_vs_set", 32'(bad_addr), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_alone",  32'(bad_addr), 32'd0);

        // Back-pressure under hold
        hold = 1'b1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 8'h81;
        bus.st_data  = 8'h01;
        @(negedge clk);
        bus.st_addr  = 8'h82;
        bus.st_data  = 8'h02;
        @(negedge clk);
        check("full_ready", 32'(bus.st_ready), 32'd0);
        bus.st_addr  = 8'h83;
        bus.st_data  = 8'h03;
        @(negedge clk);
        check("full_ready2", 32'(bus.st_ready), 32'd0);
        check("hold_we",     32'(ram_we),       32'd0);
        hold = 1'b0;
        @(negedge clk);
        check("rel1_we",   32'(ram_we),   32'd1);
        check("rel1_addr", 32'(ram_addr), 32'h81);
        @(negedge clk);
        bus.st_valid = 1'b0;
        check("rel2_we",   32'(ram_we),   32'd1);
        check("rel2_addr", 32'(ram_addr), 32'h82);
        @(negedge clk);
        check("rel3_we",   32'(ram_we),    32'd1);
        check("rel3_addr", 32'(ram_addr),  32'h83);
        check("rel3_data", 32'(ram_wdata), 32'h03);
        @(negedge clk);
        check("rel_we_off", 32'(ram_we),   32'd0);
        check("count8",     32'(wr_count), 32'd8);

        // Asynchronous reset with two entries buffered
        hold = 1'b1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 8'h84;
        bus.st_data  = 8'h44;
        @(negedge clk);
        bus.st_addr  = 8'hE5;
        bus.st_data  = 8'h55;
        @(negedge clk);
        bus.st_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(wr_count),     32'd0);
        check("arst_p03",   32'(p03),          32'h00);
        check("arst_p15",   32'(p15),          32'h00);
        check("arst_ready", 32'(bus.st_ready), 32'd1);
        check("arst_addr",  32'(ram_addr),     32'h00);
        @(negedge clk);
        hold = 1'b0;
        rst  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ram_we || (port_strobe != 16'h0000)) pulses++;
        end
        check("arst_no_commit", 32'(pulses), 32'd0);

        // 256 streamed good stores wrap wr_count
        bus.st_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.st_addr = 8'h80 + 8'(i % 96);
            bus.st_data = 8'(i);
            @(negedge clk);
        end
        bus.st_valid = 1'b0;
        check("wrap_ff",   32'(wr_count),  32'hFF);
        @(negedge clk);
        check("wrap_00",   32'(wr_count),  32'h00);
        check("wrap_addr", 32'(ram_addr),  32'hBF);
        check("wrap_data", 32'(ram_wdata), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_store_phase
`default_nettype wire
